// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: queued write payload,
// starvation FSM states and the hard-wired zero register index.
package rf_arb_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending long-latency writebacks; no bypass, so a pushed
// entry becomes visible at the head one cycle after the push edge.
module wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_req_t       mem_q [DEPTH];
  wb_req_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between the in-order writeback
// (fixed priority) and a queued long-latency requester, with anti-starvation
// bubbles and a per-register pending-write scoreboard for decode.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH    = DATA_W,
  parameter int unsigned QDEPTH        = 4,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_data,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic                     stall_req,
  input  logic                     sb_set,
  input  logic [ADDRESS_WIDTH-1:0] sb_set_addr,
  input  logic [ADDRESS_WIDTH-1:0] q_rs1,
  input  logic [ADDRESS_WIDTH-1:0] q_rs2,
  input  logic [ADDRESS_WIDTH-1:0] q_rd,
  output logic                     busy_rs1,
  output logic                     busy_rs2,
  output logic                     busy_rd
);

  localparam int unsigned NREG = 1 << ADDRESS_WIDTH;
  localparam int unsigned CW   = $clog2(STARVE_LIMIT) + 1;

  wb_req_t             push_req;
  wb_req_t             head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                grant_a;
  logic                grant_b;
  logic                starve_inc;
  arb_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NREG-1:0]     sb_q, sb_d;
  logic [ADDRESS_WIDTH-1:0] head_addr;

  assign b_ready   = !fifo_full;
  assign push      = b_valid && b_ready && (b_addr != ADDRESS_WIDTH'(ZERO_REG));
  assign push_req  = '{addr: ADDR_W'(b_addr), data: DATA_W'(b_data)};
  assign head_addr = ADDRESS_WIDTH'(head.addr);

  assign grant_a    = a_valid && (a_addr != ADDRESS_WIDTH'(ZERO_REG));
  assign grant_b    = !grant_a && !fifo_empty;
  assign starve_inc = grant_a && !fifo_empty;

  wb_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_req),
    .pop       (grant_b),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Zero-latency write-port mux; idle port drives zeros.
  always_comb begin
    we3 = 1'b0;
    ad3 = '0;
    wd3 = '0;
    if (grant_a) begin
      we3 = 1'b1;
      ad3 = a_addr;
      wd3 = a_data;
    end else if (grant_b) begin
      we3 = 1'b1;
      ad3 = head_addr;
      wd3 = DATA_WIDTH'(head.data);
    end
  end

  // Starvation FSM: a full run of A grants over a waiting queue buys one bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (starve_inc) begin
          if (cnt_q == CW'(STARVE_LIMIT - 1)) begin
            state_d = BUBBLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      BUBBLE: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign stall_req = (state_q == BUBBLE);

  // Scoreboard: a commit clears its bit, a same-cycle issue re-sets it.
  always_comb begin
    sb_d = sb_q;
    if (grant_b) begin
      sb_d[head_addr] = 1'b0;
    end
    if (sb_set) begin
      sb_d[sb_set_addr] = 1'b1;
    end
    sb_d[ZERO_REG] = 1'b0;
  end

  assign busy_rs1 = sb_q[q_rs1];
  assign busy_rs2 = sb_q[q_rs2];
  assign busy_rd  = sb_q[q_rd];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q    <= sb_d;
    end
  end

endmodule
